ddp_input_merge: RTL

- Clocked two-input packet merger that sits directly upstream of the join (matching) stage of the data-driven processor.
- Merges external packets (port A) with circulating/feedback packets (port B) into the single Send/Ack pulse interface of the join stage.
- Each input has a small FIFO plus one hold register; the output uses round-robin arbitration.
- Packets are opaque 38-bit words: {hdr[2:0], gen[7:0], node[6:0], lr, join, f1, f0, data[15:0]}.

---
 rtl/ddp_input_merge_if.sv | 44 ++++
 rtl/ddp_input_merge.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ddp_input_merge_if.sv
// ---------------------------------------------------------------------------
// ddp_input_merge_if
//   Bundles the packet-side signals of ddp_input_merge.
//   Ports A/B   : Send_in_x / PACKET_IN_x in, Ack_out_x out
//   Join stage  : Send_out / PACKET_OUT out, Ack_in in
//   Status      : CNT_A, CNT_B (FIFO occupancy), ERR (sticky violation)
//
// Handshake: every Send/Ack is an active-low, one-cycle pulse. A sender
// drives Send low for one cycle with its packet valid in that cycle. The
// receiver answers with one Ack low cycle once the packet has been stored.
// The sender must not send again until that Ack has been seen. A send that
// arrives while an earlier one is unanswered is dropped and flagged.
// ---------------------------------------------------------------------------
interface ddp_input_merge_if #(
    parameter int PW    = 38,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Send_in_a;
    logic [PW-1:0] PACKET_IN_a;
    logic          Ack_out_a;
    logic          Send_in_b;
    logic [PW-1:0] PACKET_IN_b;
    logic          Ack_out_b;
    logic          Send_out;
    logic [PW-1:0] PACKET_OUT;
    logic          Ack_in;
    logic [CW-1:0] CNT_A;
    logic [CW-1:0] CNT_B;
    logic          ERR;

    // Merger side
    modport slave (
        input  Send_in_a, PACKET_IN_a, Send_in_b, PACKET_IN_b, Ack_in,
        output Ack_out_a, Ack_out_b, Send_out, PACKET_OUT, CNT_A, CNT_B, ERR
    );

    // Environment side (senders and join stage)
    modport master (
        output Send_in_a, PACKET_IN_a, Send_in_b, PACKET_IN_b, Ack_in,
        input  Ack_out_a, Ack_out_b, Send_out, PACKET_OUT, CNT_A, CNT_B, ERR
    );
endinterface

// File: rtl/ddp_input_merge.sv
// ---------------------------------------------------------------------------
// ddp_input_merge
//   Merges external packets (port A) and feedback packets (port B) into the
//   single Send/Ack pulse interface of the join stage. Each input has a
//   DEPTH-entry FIFO plus one hold register for a packet that arrives while
//   the FIFO is full; its Ack is deferred until the packet enters the FIFO.
//   The output side is a two-state FSM with round-robin arbitration.
//
// Ports:
//   CLK          rising-edge clock
//   MR_N         asynchronous active-low master reset
//   bus          ddp_input_merge_if.slave (packet ports, status)
//   dbg_state_o  1 while the output FSM waits for Ack_in (WAIT state)
// ---------------------------------------------------------------------------
module ddp_input_merge #(
    parameter int PW    = 38,
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              MR_N,
    ddp_input_merge_if.slave  bus,
    output logic              dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    // Index 0 = port A, index 1 = port B
    logic [PW-1:0] mem_q    [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [CW-1:0] cnt_q    [2];
    logic [PW-1:0] hold_q   [2];
    logic [1:0]    pend_q;
    logic [1:0]    ack_q;      // active-high: Ack_out_x low this cycle
    logic          err_q;

    state_t        state_q, state_d;
    logic          send_out_q, send_out_d;
    logic [PW-1:0] pkt_out_q, pkt_out_d;
    logic          last_grant_q, last_grant_d;   // 0 = A, 1 = B

    logic [1:0]    send_n, not_empty, pop, space, viol;
    logic [1:0]    push_in, push_hold, capture, push;
    logic          sel;
    logic [PW-1:0] pkt_in    [2];
    logic [PW-1:0] push_data [2];

    assign send_n    = {bus.Send_in_b, bus.Send_in_a};
    assign pkt_in[0] = bus.PACKET_IN_a;
    assign pkt_in[1] = bus.PACKET_IN_b;

    // ---------------- input side (same logic for both ports) --------------
    always_comb begin
        space     = '0;
        viol      = '0;
        push_in   = '0;
        capture   = '0;
        push_hold = '0;
        push      = '0;
        for (int p = 0; p < 2; p++) begin
            // A pop on the same edge frees a slot for the incoming packet.
            space[p]     = (cnt_q[p] != CW'(DEPTH)) | pop[p];
            // Sending again before the previous packet was acked is illegal.
            viol[p]      = ~send_n[p] & (pend_q[p] | ack_q[p]);
            push_in[p]   = ~send_n[p] & ~viol[p] & space[p];
            capture[p]   = ~send_n[p] & ~viol[p] & ~space[p];
            push_hold[p] = pend_q[p] & space[p];
            // push_in and push_hold are exclusive: push_in needs pend_q=0.
            push[p]      = push_in[p] | push_hold[p];
            push_data[p] = pend_q[p] ? hold_q[p] : pkt_in[p];
        end
    end

    always_ff @(posedge CLK) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) mem_q[p][wr_ptr_q[p]] <= push_data[p];
        end
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
                hold_q[p]   <= '0;
            end
            pend_q <= '0;
            ack_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
                if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
                if (push[p] && !pop[p])      cnt_q[p] <= cnt_q[p] + CW'(1);
                else if (pop[p] && !push[p]) cnt_q[p] <= cnt_q[p] - CW'(1);
                if (capture[p]) begin
                    hold_q[p] <= pkt_in[p];
                    pend_q[p] <= 1'b1;
                end else if (push_hold[p]) begin
                    pend_q[p] <= 1'b0;
                end
            end
            ack_q <= push;
            if (|viol) err_q <= 1'b1;
        end
    end

    // ---------------- output FSM ------------------------------------------
    assign not_empty[0] = (cnt_q[0] != '0);
    assign not_empty[1] = (cnt_q[1] != '0);

    always_comb begin
        state_d      = state_q;
        send_out_d   = 1'b1;
        pkt_out_d    = pkt_out_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        sel          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|not_empty) begin
                    // Both waiting: the port that was not served last wins.
                    sel          = (&not_empty) ? ~last_grant_q : not_empty[1];
                    pop[sel]     = 1'b1;
                    pkt_out_d    = mem_q[sel][rd_ptr_q[sel]];
                    send_out_d   = 1'b0;
                    last_grant_d = sel;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.Ack_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state_q      <= ST_IDLE;
            send_out_q   <= 1'b1;
            pkt_out_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            send_out_q   <= send_out_d;
            pkt_out_q    <= pkt_out_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.Ack_out_a  = ~ack_q[0];
    assign bus.Ack_out_b  = ~ack_q[1];
    assign bus.Send_out   = send_out_q;
    assign bus.PACKET_OUT = pkt_out_q;
    assign bus.CNT_A      = cnt_q[0];
    assign bus.CNT_B      = cnt_q[1];
    assign bus.ERR        = err_q;
    assign dbg_state_o    = (state_q == ST_WAIT);

endmodule
